fx3_slave_fifo_reader: RTL
==========================

Name: fx3_slave_fifo_reader

Overview:
- Host-to-FPGA read path of the CYUSB3014 synchronous slave-FIFO interface; counterpart to the existing FPGA-to-host write path.
- Drains words from the FX3 consumer socket (DMA1) on USB_CLK into a small first-word-fall-through (FWFT) FIFO.
- Presents the words on a valid/ready stream for the command/register block.
- Shares the DQ bus with the write-path FSM through a request/grant pair. This block never drives DQ.

Parameters:
- DATA_W, 16, width of DQ and of the output stream.
- RD_LATENCY, 2, USB_CLK cycles from RD sampled low to the matching word valid on DQ_in. Legal range 1..4.
- FIFO_DEPTH, 8, capture FIFO depth. Power of 2, and at least RD_LATENCY+2.

Ports:
- USB_CLK  in  1  sole clock. All logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- DQ_in  in  DATA_W  DQ pin value as seen by the top-level tristate.
- RD  out  1  FX3 SLRD, active-low.
- OE  out  1  FX3 SLOE, active-low.
- DMA1_Ready  in  1  high = consumer socket holds data.
- DMA1_Watermark  in  1  high = more than the watermark count of words remains. Low = stop issuing reads.
- bus_req  out  1  request ownership of DQ from the write path.
- bus_grant  in  1  write path has released DQ. Held high while bus_req is high.
- out_data  out  DATA_W  head-of-FIFO word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts; a pop occurs on out_valid & out_ready.
- overflow_err  out  1  sticky; set on a capture while the FIFO is full.

Behaviour:
- Reset values (async, while rst_n=0): RD=1, OE=1, bus_req=0, out_valid=0, out_data=0, overflow_err=0. FIFO emptied, in-flight pipe cleared, FSM in IDLE.
- Reset mid-read: RD and OE return high immediately. In-flight words are discarded.

Credit:
- inflight = number of set bits in rd_pipe[RD_LATENCY-1:0].
- can_rd = (count + inflight + 1 <= FIFO_DEPTH).

FSM states:
- IDLE:
  - bus_req=0.
  - Go to REQ when DMA1_Ready=1 and count + RD_LATENCY + 1 <= FIFO_DEPTH.
- REQ:
  - bus_req=1.
  - Wait for bus_grant=1, then go to OE_SETUP.
  - If DMA1_Ready falls before the grant, go to RELEASE.
- OE_SETUP:
  - OE=0 for exactly 1 cycle. RD=1.
  - Go to READ.
- READ:
  - OE=0. RD=0 in every cycle where DMA1_Ready & DMA1_Watermark & can_rd.
  - If DMA1_Ready=0 or DMA1_Watermark=0, go to DRAIN (RD=1 that cycle).
  - If only can_rd=0, stay in READ with RD=1.
- DRAIN:
  - OE=0, RD=1.
  - Hold for exactly RD_LATENCY cycles (counter), then go to RELEASE.
- RELEASE:
  - OE=1, bus_req=0 for 1 cycle.
  - Go to IDLE. Re-request is allowed on the next cycle.

Capture:
- rd_pipe shifts every cycle. Its input is (RD==0) as driven that cycle.
- When rd_pipe[RD_LATENCY-1]=1, DQ_in is pushed into the FIFO.
- The word issued by RD low in cycle N is pushed at the edge ending cycle N+RD_LATENCY.

FIFO:
- FWFT: out_data equals the head whenever out_valid=1.
- Push and pop in the same cycle: count unchanged. This is allowed at full and at empty (at empty the push bypasses nothing; out_valid rises the next cycle).
- Latency from push to out_valid = 1 cycle.
- Pointers wrap modulo FIFO_DEPTH.
- The credit rule makes overflow unreachable. Any push at count==FIFO_DEPTH drops the word and sets overflow_err until reset.

Bus rules:
- OE is never low unless bus_grant=1.
- bus_req drops only in RELEASE or IDLE.

Test Plan:
1. Basic burst: DMA1_Ready=1, Watermark high for 6 read cycles then low, out_ready=1, DQ_in = 0x1000+n on capture cycles. Expect 6 RD-low cycles, DRAIN of 2 cycles, and out_data sequence 0x1000..0x1005 in order. overflow_err stays 0.
2. Backpressure: out_ready=0 with FIFO_DEPTH=8 and a long transfer. RD stops once count+inflight reaches 8. Exactly 8 words are stored, out_valid=1 and overflow_err=0. Raising out_ready resumes RD within 1 cycle of a credit freeing.
3. Grant delay: bus_grant held low for 5 cycles after bus_req. OE and RD stay high throughout. OE falls the cycle after the grant, and the first RD is one cycle after that.
4. Ready drop: DMA1_Ready falls mid-READ after 3 reads. No further RD. All 3 words are delivered. bus_req falls exactly RD_LATENCY+1 cycles after the drop.
5. Simultaneous push/pop at full: FIFO full, out_ready=1 pulsed in the same cycle as a capture. count stays 8 and data order is preserved.
6. Async reset mid-READ: rst_n low for 1 cycle with 2 words in flight. RD=OE=1 and bus_req=0 immediately. out_valid=0. No stale word appears after release.

Source files
------------

// File: rtl/fx3_slave_fifo_reader.sv
// fx3_slave_fifo_reader: drains the FX3 consumer socket into an FWFT FIFO behind a valid/ready stream
module fx3_slave_fifo_reader #(
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              USB_CLK,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] DQ_in,
  output logic              RD,
  output logic              OE,
  input  logic              DMA1_Ready,
  input  logic              DMA1_Watermark,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam int SW = AW + 2;
  typedef enum logic [2:0] {IDLE, REQ, OE_SETUP, READ, DRAIN, RELEASE} state_t;
  state_t                state_q, state_d;
  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic [CW-1:0]         drain_cnt_q, drain_cnt_d, inflight;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
  logic                  can_rd, start_ok, drain_done, push, pop, full, wr_en;

  // Credit: a read may issue only if the word has a guaranteed FIFO slot when it lands
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(rd_pipe_q[i]);
    can_rd = SW'(count_q) + SW'(inflight) + SW'(1) <= SW'(FIFO_DEPTH);
    start_ok = SW'(count_q) + SW'(RD_LATENCY + 1) <= SW'(FIFO_DEPTH);
  end

  // Next-state logic; DRAIN lasts exactly RD_LATENCY cycles so every issued word lands before release
  always_comb begin
    state_d = state_q;
    drain_cnt_d = (state_q == DRAIN) ? drain_cnt_q + 1'b1 : '0;
    drain_done = drain_cnt_q == CW'(RD_LATENCY - 1);
    case (state_q)
      IDLE:     state_d = (DMA1_Ready && start_ok) ? REQ : IDLE;
      REQ:      state_d = bus_grant ? OE_SETUP : (!DMA1_Ready ? RELEASE : REQ);
      OE_SETUP: state_d = READ;
      READ:     state_d = (!DMA1_Ready || !DMA1_Watermark) ? DRAIN : READ;
      DRAIN:    state_d = drain_done ? RELEASE : DRAIN;
      RELEASE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Pin outputs; OE/RD are additionally gated by grant so DQ is never contended
  always_comb begin
    bus_req = state_q inside {REQ, OE_SETUP, READ, DRAIN};
    OE = !(bus_grant && (state_q inside {OE_SETUP, READ, DRAIN}));
    RD = !(bus_grant && state_q == READ && DMA1_Ready && DMA1_Watermark && can_rd);
  end

  // Capture pipe and FIFO bookkeeping; a push at full without a pop is dropped and flagged
  always_comb begin
    rd_pipe_d[0] = !RD;
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
    push = rd_pipe_q[RD_LATENCY-1];
    pop = out_valid && out_ready;
    full = count_q == (AW+1)'(FIFO_DEPTH);
    wr_en = push && (!full || pop);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    ovf_d = ovf_q || (push && full && !pop);
  end

  assign out_valid = count_q != '0;
  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow_err = ovf_q;

  // Storage array needs no reset; the head is masked while empty
  always_ff @(posedge USB_CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= DQ_in;
  end

  // State registers; reset discards in-flight reads and empties the FIFO
  always_ff @(posedge USB_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_pipe_q <= '0;
      drain_cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_pipe_q <= rd_pipe_d;
      drain_cnt_q <= drain_cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
